// File: rtl/fetch_issue_frontend.sv
// Fetch/issue front end: sequential-PC fetch with several requests in flight, in-order instruction
// queue, redirect flush and end-of-program detection. Define FE_PERF_CNT_EN for performance counters.
module fetch_issue_frontend #(
    parameter int PC_BIT          = 8,
    parameter int INST_ID_BIT     = 8,
    parameter int INST_BIT        = 16,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PC_STRIDE       = 1,
    parameter int NUM_FU          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fetch_vld,
    input  logic                   fetch_rdy,
    output logic [INST_ID_BIT-1:0] fetch_id,
    output logic [PC_BIT-1:0]      fetch_pc,
    input  logic                   resp_vld,
    output logic                   resp_rdy,
    input  logic [INST_BIT-1:0]    resp_inst,
    input  logic                   resp_last,
    output logic                   issue_vld,
    input  logic                   issue_rdy,
    output logic [INST_ID_BIT-1:0] issue_id,
    output logic [PC_BIT-1:0]      issue_pc,
    output logic [INST_BIT-1:0]    issue_inst,
    output logic                   issue_last,
    input  logic                   redirect_vld,
    input  logic [PC_BIT-1:0]      redirect_pc,
    input  logic [NUM_FU-1:0]      fu_idle,
    output logic                   exec_finish
`ifdef FE_PERF_CNT_EN
    ,
    output logic [15:0]            perf_fetch_cnt,
    output logic [15:0]            perf_drop_cnt,
    output logic [15:0]            perf_stall_cnt
`endif
);

    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_LAST_SEEN,
        S_LAST_ISSUED,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PC_BIT-1:0]      r_fetch_pc;
    logic [INST_ID_BIT-1:0] r_fetch_id;
    logic [IW-1:0]          r_inflight;
    logic [IW-1:0]          w_inflight_nxt;
    logic [IW-1:0]          r_drop;

    // Tag/PC of every request in flight; responses return in order so a FIFO suffices.
    logic [INST_ID_BIT-1:0] r_tag_id [MAX_OUTSTANDING];
    logic [PC_BIT-1:0]      r_tag_pc [MAX_OUTSTANDING];
    logic [TW-1:0]          r_tag_wptr;
    logic [TW-1:0]          r_tag_rptr;

    logic [INST_ID_BIT-1:0] r_q_id   [QUEUE_DEPTH];
    logic [PC_BIT-1:0]      r_q_pc   [QUEUE_DEPTH];
    logic [INST_BIT-1:0]    r_q_inst [QUEUE_DEPTH];
    logic                   r_q_last [QUEUE_DEPTH];
    logic [QW-1:0]          r_q_wptr;
    logic [QW-1:0]          r_q_rptr;
    logic [CW-1:0]          r_q_count;

    logic          w_fetch_hs;
    logic          w_resp_hs;
    logic          w_issue_hs;
    logic          w_redirect;
    logic          w_enq;
    logic          w_last_enq;
    logic [SW-1:0] w_occupancy;

    function automatic logic [TW-1:0] tag_ptr_inc(input logic [TW-1:0] p);
        if (p == TW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign resp_rdy       = 1'b1;
    assign fetch_pc       = r_fetch_pc;
    assign fetch_id       = r_fetch_id;
    assign exec_finish    = (r_state == S_FINISH);
    assign issue_id       = r_q_id[r_q_rptr];
    assign issue_pc       = r_q_pc[r_q_rptr];
    assign issue_inst     = r_q_inst[r_q_rptr];
    assign issue_last     = r_q_last[r_q_rptr];

    assign w_fetch_hs     = fetch_vld && fetch_rdy;
    assign w_resp_hs      = resp_vld && resp_rdy;
    assign w_issue_hs     = issue_vld && issue_rdy;
    assign w_redirect     = redirect_vld && ((r_state == S_RUN) || (r_state == S_LAST_SEEN));
    // Anything after the last instruction, or still in flight at a redirect, never enters the queue.
    assign w_enq          = w_resp_hs && (r_drop == '0) && !w_redirect && (r_state == S_RUN);
    assign w_last_enq     = w_enq && resp_last;
    assign w_occupancy    = SW'(r_inflight) + SW'(r_q_count);
    assign w_inflight_nxt = r_inflight + IW'(w_fetch_hs) - IW'(w_resp_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fetch_vld   = 1'b0;
        issue_vld   = 1'b0;
        case (r_state)
            S_RUN: begin
                fetch_vld = !rst && !redirect_vld &&
                            (r_inflight < IW'(MAX_OUTSTANDING)) &&
                            (w_occupancy < SW'(QUEUE_DEPTH));
                issue_vld = (r_q_count != '0);
                if (w_last_enq && !w_redirect) begin
                    w_state_nxt = S_LAST_SEEN;
                end
            end
            S_LAST_SEEN: begin
                issue_vld = (r_q_count != '0);
                if (w_redirect) begin
                    w_state_nxt = S_RUN;
                end else if ((r_q_count != '0) && issue_rdy && issue_last) begin
                    w_state_nxt = S_LAST_ISSUED;
                end
            end
            S_LAST_ISSUED: begin
                if (&fu_idle) begin
                    w_state_nxt = S_FINISH;
                end
            end
            default: begin
                w_state_nxt = S_FINISH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= '0;
            r_fetch_id <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_q_count  <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_fetch_hs) begin
                r_fetch_pc <= r_fetch_pc + PC_BIT'(PC_STRIDE);
            end
            // The tag counter runs across redirects so reissued PCs never reuse a live tag.
            if (w_fetch_hs) begin
                r_fetch_id <= r_fetch_id + 1'b1;
                r_tag_wptr <= tag_ptr_inc(r_tag_wptr);
            end
            if (w_resp_hs) begin
                r_tag_rptr <= tag_ptr_inc(r_tag_rptr);
            end
            if (w_redirect || w_last_enq) begin
                r_drop <= w_inflight_nxt;
            end else if (w_resp_hs && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
            if (w_enq) begin
                r_q_wptr <= r_q_wptr + 1'b1;
            end
            if (w_redirect) begin
                r_q_rptr  <= r_q_wptr;
                r_q_count <= '0;
            end else begin
                if (w_issue_hs) begin
                    r_q_rptr <= r_q_rptr + 1'b1;
                end
                r_q_count <= r_q_count + CW'(w_enq) - CW'(w_issue_hs);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fetch_hs) begin
            r_tag_id[r_tag_wptr] <= r_fetch_id;
            r_tag_pc[r_tag_wptr] <= r_fetch_pc;
        end
        if (w_enq) begin
            r_q_id[r_q_wptr]   <= r_tag_id[r_tag_rptr];
            r_q_pc[r_q_wptr]   <= r_tag_pc[r_tag_rptr];
            r_q_inst[r_q_wptr] <= resp_inst;
            r_q_last[r_q_wptr] <= resp_last;
        end
    end

`ifdef FE_PERF_CNT_EN
    logic        w_discard;
    logic [15:0] r_perf_fetch;
    logic [15:0] r_perf_drop;
    logic [15:0] r_perf_stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_discard = w_resp_hs && !w_enq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch_hs) begin
                r_perf_fetch <= sat_inc(r_perf_fetch);
            end
            if (w_discard) begin
                r_perf_drop <= sat_inc(r_perf_drop);
            end
            if ((r_state == S_RUN) && !fetch_vld) begin
                r_perf_stall <= sat_inc(r_perf_stall);
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_issue_frontend.sv
// Randomized scoreboard bench for fetch_issue_frontend: a queue-based reference model predicts
// fetch behaviour and the issue stream; a separate monitor checks every presented issue entry.
module tb_fetch_issue_frontend;

    localparam int PCB = 8;
    localparam int IDB = 8;
    localparam int INB = 16;
    localparam int QD  = 4;
    localparam int MO  = 4;
    localparam int STR = 1;
    localparam int NFU = 8;

    localparam int S_RUN      = 0;
    localparam int S_SEEN     = 1;
    localparam int S_ISSUED   = 2;
    localparam int S_FINISH   = 3;

    typedef struct packed {
        logic [IDB-1:0] id;
        logic [PCB-1:0] pc;
    } req_t;

    typedef struct packed {
        logic [IDB-1:0] id;
        logic [PCB-1:0] pc;
        logic [INB-1:0] inst;
        logic           last;
    } ent_t;

    logic           clk;
    logic           rst;
    logic           fetch_vld;
    logic           fetch_rdy;
    logic [IDB-1:0] fetch_id;
    logic [PCB-1:0] fetch_pc;
    logic           resp_vld;
    logic           resp_rdy;
    logic [INB-1:0] resp_inst;
    logic           resp_last;
    logic           issue_vld;
    logic           issue_rdy;
    logic [IDB-1:0] issue_id;
    logic [PCB-1:0] issue_pc;
    logic [INB-1:0] issue_inst;
    logic           issue_last;
    logic           redirect_vld;
    logic [PCB-1:0] redirect_pc;
    logic [NFU-1:0] fu_idle;
    logic           exec_finish;

    fetch_issue_frontend #(
        .PC_BIT(PCB), .INST_ID_BIT(IDB), .INST_BIT(INB), .QUEUE_DEPTH(QD),
        .MAX_OUTSTANDING(MO), .PC_STRIDE(STR), .NUM_FU(NFU)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_id(fetch_id), .fetch_pc(fetch_pc),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_inst(resp_inst), .resp_last(resp_last),
        .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_id(issue_id), .issue_pc(issue_pc),
        .issue_inst(issue_inst), .issue_last(issue_last),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .fu_idle(fu_idle), .exec_finish(exec_finish)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    req_t           pend[$];
    ent_t           expq[$];
    logic [PCB-1:0] m_pc = '0;
    logic [IDB-1:0] m_id = '0;
    int             m_drop = 0;
    int             m_state = S_RUN;
    bit             popped_last = 0;

    // Stimulus knobs (percent, redirect in per-mille)
    int             k_frdy = 0;
    int             k_resp = 0;
    int             k_issue = 0;
    int             k_redir = 0;
    bit             fu_all = 0;
    bit             last_armed = 0;
    logic [IDB-1:0] last_target = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: checks fetch-side outputs at the falling edge, then books this cycle's handshakes.
    always @(negedge clk) begin : model
        bit   fv_exp;
        bit   redir;
        bit   enq_last;
        req_t r;
        ent_t e;
        if (rst) begin
            chk("fetch_vld_in_reset", fetch_vld, 1'b0);
            #2;
            pend.delete();
            expq.delete();
            m_pc = '0;
            m_id = '0;
            m_drop = 0;
            m_state = S_RUN;
            popped_last = 0;
        end else begin
            fv_exp = (m_state == S_RUN) && (pend.size() < MO) &&
                     (pend.size() + expq.size() < QD) && !redirect_vld;
            chk("fetch_vld", fetch_vld, fv_exp);
            chk("resp_rdy", resp_rdy, 1'b1);
            chk("exec_finish", exec_finish, m_state == S_FINISH);
            if (fv_exp) begin
                chk("fetch_pc", fetch_pc, m_pc);
                chk("fetch_id", fetch_id, m_id);
            end
            #2;
            redir = redirect_vld && (m_state <= S_SEEN);
            enq_last = 0;
            if (resp_vld && pend.size() > 0) begin
                r = pend.pop_front();
                if (redir) begin
                end else if (m_drop > 0) begin
                    m_drop--;
                end else if (m_state == S_RUN) begin
                    e.id = r.id;
                    e.pc = r.pc;
                    e.inst = resp_inst;
                    e.last = resp_last;
                    expq.push_back(e);
                    enq_last = resp_last;
                end
            end
            if (fv_exp && fetch_rdy) begin
                r.id = m_id;
                r.pc = m_pc;
                pend.push_back(r);
                m_id = m_id + 8'd1;
                m_pc = m_pc + PCB'(STR);
            end
            if (redir) begin
                expq.delete();
                m_drop = pend.size();
                m_pc = redirect_pc;
                m_state = S_RUN;
            end else begin
                case (m_state)
                    S_RUN:    if (enq_last) begin m_state = S_SEEN; m_drop = pend.size(); end
                    S_SEEN:   if (popped_last) m_state = S_ISSUED;
                    S_ISSUED: if (&fu_idle) m_state = S_FINISH;
                    default:  ;
                endcase
            end
            popped_last = 0;
        end
    end

    // Monitor: compares whatever the DUT presents on the issue port against the scoreboard head.
    always @(negedge clk) begin : monitor
        ent_t e;
        #1;
        if (!rst) begin
            chk("issue_vld", issue_vld, (expq.size() > 0) && (m_state <= S_SEEN));
            if (issue_vld && expq.size() > 0) begin
                e = expq[0];
                chk("issue_id", issue_id, e.id);
                chk("issue_pc", issue_pc, e.pc);
                chk("issue_inst", issue_inst, e.inst);
                chk("issue_last", issue_last, e.last);
                if (issue_rdy) begin
                    void'(expq.pop_front());
                    popped_last = e.last;
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fetch_rdy    = ($urandom_range(99) < k_frdy);
            resp_vld     = (pend.size() > 0) && ($urandom_range(99) < k_resp);
            resp_inst    = INB'($urandom);
            resp_last    = 1'b0;
            if (resp_vld && last_armed) begin
                resp_last = (pend[0].id == last_target);
            end
            issue_rdy    = ($urandom_range(99) < k_issue);
            redirect_vld = ($urandom_range(999) < k_redir);
            redirect_pc  = PCB'($urandom);
            fu_idle      = fu_all ? '1 : (NFU'($urandom) & 8'hFE);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_rdy = 1'b0;
        resp_vld = 1'b0;
        resp_last = 1'b0;
        issue_rdy = 1'b0;
        redirect_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_issue_vld", issue_vld, 1'b0);
        chk("post_reset_fetch_pc", fetch_pc, 8'h00);
        chk("post_reset_fetch_id", fetch_id, 8'h00);
        chk("post_reset_exec_finish", exec_finish, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        fetch_rdy = 1'b0;
        resp_vld = 1'b0;
        resp_inst = '0;
        resp_last = 1'b0;
        issue_rdy = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc = '0;
        fu_idle = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        k_frdy = 100; k_resp = 100; k_issue = 100; k_redir = 0;
        step(40);

        k_issue = 0; k_resp = 70;
        step(20);
        k_issue = 100;
        step(20);

        k_frdy = 70; k_resp = 60; k_issue = 60; k_redir = 40;
        step(400);
        k_frdy = 100; k_resp = 90; k_issue = 90; k_redir = 150;
        step(200);

        k_redir = 0; k_frdy = 80; k_resp = 70; k_issue = 70;
        last_target = m_id + 8'd5;
        last_armed = 1;
        for (int i = 0; i < 500 && m_state != S_ISSUED; i++) step(1);
        step(3);
        fu_all = 1;
        for (int i = 0; i < 20 && exec_finish !== 1'b1; i++) step(1);
        chk("exec_finish_reached", exec_finish, 1'b1);
        k_redir = 1000;
        step(1);
        k_redir = 0;
        step(5);
        last_armed = 0;
        fu_all = 0;
        do_reset();

        k_frdy = 100; k_resp = 100; k_issue = 0;
        step(12);
        do_reset();
        k_issue = 100;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/fetch_issue_frontend.md
Name: fetch_issue_frontend

Overview:
- Parametrised instruction front end for the out-of-order CPU.
- Issues sequential PC fetch requests with several requests outstanding at once.
- Buffers in-order fetch responses in an instruction queue and presents them to the scoreboard issue port.
- Supports PC redirect with flush of queued and in-flight instructions, and produces exec_finish once the last instruction has issued and all FUs are idle.

Parameters:
- PC_BIT, 8, fetch PC width
- INST_ID_BIT, 8, instruction tag width
- INST_BIT, 16, raw instruction word width
- QUEUE_DEPTH, 4, instruction queue entries (power of 2, >=2)
- MAX_OUTSTANDING, 4, maximum fetch requests in flight (<= QUEUE_DEPTH)
- PC_STRIDE, 1, PC increment per fetch
- NUM_FU, 8, number of function units reporting idle

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_vld  out  1  fetch request valid
- fetch_rdy  in  1  memory accepts request
- fetch_id  out  INST_ID_BIT  tag of request
- fetch_pc  out  PC_BIT  address of request
- resp_vld  in  1  fetch response valid (returned in request order)
- resp_rdy  out  1  response accept
- resp_inst  in  INST_BIT  instruction word
- resp_last  in  1  instruction is program end
- issue_vld  out  1  queue head valid
- issue_rdy  in  1  scoreboard accepts
- issue_id  out  INST_ID_BIT  head tag
- issue_pc  out  PC_BIT  head PC
- issue_inst  out  INST_BIT  head instruction word
- issue_last  out  1  head is program end
- redirect_vld  in  1  one-cycle redirect pulse
- redirect_pc  in  PC_BIT  new fetch PC
- fu_idle  in  NUM_FU  per-FU idle
- exec_finish  out  1  program complete

Behaviour:
- Reset: fetch_pc=0, fetch_id=0, queue empty, in-flight=0, drop=0, state RUN.
  - Outputs after reset: fetch_vld=0 for the reset cycle, issue_vld=0, exec_finish=0, resp_rdy=1.
- Credit rule: fetch_vld = (state==RUN) && inflight<MAX_OUTSTANDING && (inflight+queue_count)<QUEUE_DEPTH && !redirect_vld.
  - Any response is guaranteed queue space, so resp_rdy is held at 1.
- On a fetch handshake: fetch_pc += PC_STRIDE (mod 2^PC_BIT), fetch_id += 1 (mod 2^INST_ID_BIT), inflight += 1.
- On a response handshake: inflight -= 1.
  - If drop>0: response discarded, drop -= 1.
  - Otherwise: enqueue {id,pc,inst,last}. id and pc come from an internal FIFO of issued tags/PCs of depth MAX_OUTSTANDING.
  - Enqueue is visible on issue_* the next cycle (1-cycle latency when the queue is empty).
- Fetch and response in the same cycle: inflight unchanged.
- Enqueue and dequeue in the same cycle while full: legal; count unchanged.
- Pointer wrap: pointers are modulo QUEUE_DEPTH.
- Queue head: issue_* driven from the head entry; dequeue on issue_vld && issue_rdy. issue_* remain stable while issue_vld=1 and issue_rdy=0.
- States:
  - RUN: normal operation. An enqueued entry with last=1 -> LAST_SEEN; fetching stops from the next cycle.
  - LAST_SEEN: fetch_vld=0. Responses still arriving after the last are dropped (drop += inflight on entry). Dequeue of the last entry -> LAST_ISSUED.
  - LAST_ISSUED: fetch_vld=0, issue_vld=0. When &fu_idle -> FINISH.
  - FINISH: exec_finish=1 (registered) until rst.
- redirect_vld in RUN or LAST_SEEN:
  - Queue flushed and drop = inflight (counting a same-cycle response as already consumed).
  - fetch_pc = redirect_pc; fetch_id keeps incrementing, so tags stay unique.
  - State -> RUN; fetch_vld=0 that cycle.
  - A same-cycle issue handshake is still honoured; the flush removes the remaining entries.
- redirect_vld in LAST_ISSUED or FINISH: ignored.
- rst mid-operation: all state and counters cleared immediately. Responses still in flight at memory are the environment's responsibility.

Optional Feature:
- Macro FE_PERF_CNT_EN.
- When defined, adds three outputs, each 16 bits: perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt.
  - perf_fetch_cnt counts fetch handshakes.
  - perf_drop_cnt counts discarded responses.
  - perf_stall_cnt counts cycles in RUN with fetch_vld=0.
- Counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Streaming: fetch_rdy=1, resp 1 cycle after request, issue_rdy=1 -> ids 0,1,2… issued in order with pc 0,1,2…; fetch_vld never drops.
- Back-pressure: issue_rdy=0 -> at most 4 fetch handshakes (QUEUE_DEPTH=4) then fetch_vld=0. issue_rdy=1 -> entries drain in order and fetching resumes.
- Redirect: 3 requests in flight and 2 queued, redirect_pc=8'h40 -> queue empties, next 3 responses dropped, next issued pc=8'h40 with a fresh id.
- Last: response 5 carries last=1, responses 6-7 in flight -> 6-7 dropped, issue_last=1 on id 5, no further fetch; exec_finish rises 1 cycle after fu_idle becomes all-ones.
- Simultaneous: redirect in the same cycle as a response and an issue handshake -> the issue completes, the response is not enqueued, drop equals the remaining in-flight count.
- Reset mid-run with queue full -> next cycle issue_vld=0, fetch_pc=0, fetch_id=0, exec_finish=0.
